rv_muldiv_unit: RTL

// - Multi-cycle RV32M execute unit: MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU.
// - Sits beside the single-cycle ALU in EX and takes all M-extension ops off it.
// - valid/ready in and out, so EX stalls while the unit is busy.
// - Full RISC-V divide-by-zero and signed-overflow semantics.

---
 rtl/rv_pkg.sv | 25 ++
 rtl/rv_div_core.sv | 39 +++
 rtl/rv_muldiv_unit.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/rv_pkg.sv
// Shared types for the RV32M multiply/divide unit.
// Holds the funct3 op encoding, FSM states and the default operand width.
package rv_pkg;

    localparam int XLEN_DEF = 32;

    // funct3 encoding of the M-extension ops
    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } md_state_e;

endpackage

// File: rtl/rv_div_core.sv
// One radix-2 iteration: restoring divide step, or shift-add multiply step.
// Ports: i_mul selects multiply; i_rem/i_quo/i_div in, o_rem/o_quo next values.
module rv_div_core #(
    parameter int XLEN = 32
) (
    input  logic            i_mul,
    input  logic [XLEN-1:0] i_rem,
    input  logic [XLEN-1:0] i_quo,
    input  logic [XLEN-1:0] i_div,
    output logic [XLEN-1:0] o_rem,
    output logic [XLEN-1:0] o_quo
);

    logic [XLEN:0] w_sh;
    logic [XLEN:0] w_diff;
    logic [XLEN:0] w_sum;

    // Divide: {rem,quo} shifts left; subtract if it fits.
    // Multiply: {rem,quo} is {hi,lo} of the product; add then shift right.
    assign w_sh   = {i_rem, i_quo[XLEN-1]};
    assign w_diff = w_sh - {1'b0, i_div};
    assign w_sum  = {1'b0, i_rem} + (i_quo[0] ? {1'b0, i_div} : '0);

    always_comb begin
        o_rem = '0;
        o_quo = '0;
        if (i_mul) begin
            o_rem = w_sum[XLEN:1];
            o_quo = {w_sum[0], i_quo[XLEN-1:1]};
        end else if (!w_diff[XLEN]) begin
            o_rem = w_diff[XLEN-1:0];
            o_quo = {i_quo[XLEN-2:0], 1'b1};
        end else begin
            o_rem = w_sh[XLEN-1:0];
            o_quo = {i_quo[XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/rv_muldiv_unit.sv
// Multi-cycle RV32M execute unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
// Ports: in_valid/in_ready/md_op/oprnd_a/oprnd_b in, out_valid/out_ready/md_out out, flush, busy.
module rv_muldiv_unit
    import rv_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter bit FAST_MUL = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  md_op_e          md_op,
    input  logic [XLEN-1:0] oprnd_a,
    input  logic [XLEN-1:0] oprnd_b,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] md_out,
    output logic            busy
);

    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

    md_state_e       r_state;
    md_op_e          r_op;
    logic            r_neg;
    logic [5:0]      r_iter;
    logic [XLEN-1:0] r_rem;
    logic [XLEN-1:0] r_quo;
    logic [XLEN-1:0] r_div;
    logic [XLEN-1:0] r_md_out;
    logic            r_out_valid;

    logic              w_is_div;
    logic              w_sa;
    logic              w_sb;
    logic              w_neg;
    logic [XLEN-1:0]   w_abs_a;
    logic [XLEN-1:0]   w_abs_b;
    logic              w_b_zero;
    logic              w_ovf;
    logic              w_special;
    logic [XLEN-1:0]   w_spec_res;
    logic [2*XLEN-1:0] w_pf;
    logic [2*XLEN-1:0] w_pf_s;
    logic [XLEN-1:0]   w_fast_res;
    logic [XLEN-1:0]   w_nrem;
    logic [XLEN-1:0]   w_nquo;
    logic [2*XLEN-1:0] w_pi;
    logic [2*XLEN-1:0] w_pi_s;
    logic [XLEN-1:0]   w_q;
    logic [XLEN-1:0]   w_r;
    logic [XLEN-1:0]   w_iter_res;

    // Operand signedness: DIV/REM have bit0 clear; MULHSU signs only rs1.
    assign w_is_div = md_op[2];
    assign w_sa = oprnd_a[XLEN-1] &
                  (w_is_div ? ~md_op[0]
                            : (md_op == MD_MULH || md_op == MD_MULHSU));
    assign w_sb = oprnd_b[XLEN-1] &
                  (w_is_div ? ~md_op[0] : (md_op == MD_MULH));
    assign w_abs_a = w_sa ? -oprnd_a : oprnd_a;
    assign w_abs_b = w_sb ? -oprnd_b : oprnd_b;
    // Remainder follows the dividend sign; everything else xors.
    assign w_neg = (w_is_div & md_op[1]) ? w_sa : (w_sa ^ w_sb);

    assign w_b_zero  = (oprnd_b == '0);
    assign w_ovf     = w_is_div & ~md_op[0] &
                       (oprnd_a == MIN_VAL) & (&oprnd_b);
    assign w_special = w_is_div & (w_b_zero | w_ovf);
    assign w_spec_res = w_b_zero ? (md_op[1] ? oprnd_a : '1)
                                 : (md_op[1] ? '0 : MIN_VAL);

    assign w_pf   = {{XLEN{1'b0}}, w_abs_a} * {{XLEN{1'b0}}, w_abs_b};
    assign w_pf_s = w_neg ? -w_pf : w_pf;
    assign w_fast_res = (md_op == MD_MUL) ? w_pf_s[XLEN-1:0]
                                          : w_pf_s[2*XLEN-1:XLEN];

    rv_div_core #(.XLEN(XLEN)) u_core (
        .i_mul (~r_op[2]),
        .i_rem (r_rem),
        .i_quo (r_quo),
        .i_div (r_div),
        .o_rem (w_nrem),
        .o_quo (w_nquo)
    );

    // Sign fixup applied to the last iteration's output on DONE entry.
    assign w_pi   = {w_nrem, w_nquo};
    assign w_pi_s = r_neg ? -w_pi : w_pi;
    assign w_q    = r_neg ? -w_nquo : w_nquo;
    assign w_r    = r_neg ? -w_nrem : w_nrem;
    assign w_iter_res = r_op[2] ? (r_op[1] ? w_r : w_q)
                      : ((r_op == MD_MUL) ? w_pi_s[XLEN-1:0]
                                          : w_pi_s[2*XLEN-1:XLEN]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_op        <= MD_MUL;
            r_neg       <= 1'b0;
            r_iter      <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_div       <= '0;
            r_md_out    <= '0;
            r_out_valid <= 1'b0;
        end else if (flush) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_iter      <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_op   <= md_op;
                        r_neg  <= w_neg;
                        r_iter <= '0;
                        r_rem  <= '0;
                        r_quo  <= w_abs_a;
                        r_div  <= w_abs_b;
                        if (w_special) begin
                            r_md_out    <= w_spec_res;
                            r_out_valid <= 1'b1;
                            r_state     <= DONE;
                        end else if (FAST_MUL && !w_is_div) begin
                            r_md_out    <= w_fast_res;
                            r_out_valid <= 1'b1;
                            r_state     <= DONE;
                        end else begin
                            r_state <= CALC;
                        end
                    end
                end
                CALC: begin
                    r_rem  <= w_nrem;
                    r_quo  <= w_nquo;
                    r_iter <= r_iter + 6'd1;
                    if (r_iter == 6'(XLEN-1)) begin
                        r_iter      <= '0;
                        r_md_out    <= w_iter_res;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign busy      = (r_state != IDLE);
    assign out_valid = r_out_valid;
    assign md_out    = r_md_out;

endmodule
